// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, types and round-robin pick function for the adder arbiter
//
// Purpose:
//   Default sizing for the shared-adder arbiter and the round-robin winner
//   search used by adder_arbiter. rr_pick is written against the largest
//   supported requester count (MAX_REQ) so one function serves every
//   NUM_REQ from 2 to 8; callers zero-extend their request vector and
//   pointer and pass the live requester count in n.
//
// Contents:
//   NUM_REQ_DEF, WIDTH_DEF  default parameter values
//   MAX_REQ, MAX_IDX_W      upper bound on requesters and its index width
//   rr_pick_t               {found, idx} result of a round-robin search
//   rr_pick()               first valid requester at or after ptr, wrapping mod n

package adder_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int WIDTH_DEF   = 32;

  localparam int MAX_REQ     = 8;
  localparam int MAX_IDX_W   = 3;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scans ptr, ptr+1, ..., ptr+n-1 (mod n) and returns the first index whose
  // valid bit is set. Offsets at or beyond n are skipped so bits above the
  // live requester count never win.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0]   valid,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    rr_pick_t    r;
    int unsigned cand;
    r.found = 1'b0;
    r.idx   = '0;
    cand    = 0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      cand = (32'(ptr) + off) % n;
      if (!r.found && (off < n) && valid[cand[MAX_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[MAX_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_core.sv
// rtl/adder_core.sv - combinational wrap-around adder with carry-out and signed overflow
//
// Purpose:
//   The single shared adder. Pure combinational; the arbiter registers
//   its outputs.
//
// Ports:
//   a_i      in  WIDTH  operand A
//   b_i      in  WIDTH  operand B
//   sum_o    out WIDTH  (A+B) mod 2^WIDTH
//   carry_o  out 1      unsigned carry-out of A+B
//   ovf_o    out 1      two's-complement overflow of A+B

module adder_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum_wide;

  // One extra bit so the unsigned carry falls out of the top position.
  assign sum_wide = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = sum_wide[WIDTH-1:0];
  assign carry_o  = sum_wide[WIDTH];

  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                 (sum_wide[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder among NUM_REQ requesters
//
// Purpose:
//   Grants one requester per cycle to a shared WIDTH-bit adder and holds the
//   result in a one-deep output register until the owning requester takes
//   it. A drain and a new accept can happen on the same edge, so the block
//   sustains one addition per cycle.
//
// Ports:
//   clk        in  1              rising-edge clock
//   rst_n      in  1              asynchronous active-low reset
//   req_valid  in  NUM_REQ        per-requester operation request
//   req_a      in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in  NUM_REQ*WIDTH  operand B, same packing
//   req_ready  out NUM_REQ        one-hot grant (zero while in reset)
//   rsp_valid  out NUM_REQ        one-hot owner of the held result
//   rsp_ready  in  NUM_REQ        owner consumes result; non-owner bits ignored
//   rsp_sum    out WIDTH          (A+B) mod 2^WIDTH
//   rsp_ovf    out 1              signed overflow
//   rsp_carry  out 1              unsigned carry-out
//   rsp_id     out IDX_W          index of the owning requester

module adder_arbiter
  import adder_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf,
  output logic                     rsp_carry,
  output logic [IDX_W-1:0]         rsp_id
);

  // Registered output stage and round-robin pointer.
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q,   rsp_sum_d;
  logic               rsp_ovf_q,   rsp_ovf_d;
  logic               rsp_carry_q, rsp_carry_d;
  logic [IDX_W-1:0]   rsp_id_q,    rsp_id_d;
  logic [IDX_W-1:0]   ptr_q,       ptr_d;

  // Arbitration and datapath.
  rr_pick_t           pick;
  logic [NUM_REQ-1:0] grant_oh;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   core_sum;
  logic               core_carry;
  logic               core_ovf;

  // Handshake.
  logic               out_busy;
  logic               drain;
  logic               can_accept;
  logic               accept;

  assign pick = rr_pick(MAX_REQ'(req_valid), MAX_IDX_W'(ptr_q), unsigned'(NUM_REQ));

  // Operand mux driven by the winner; decoded as a one-hot loop so an index
  // never reaches past the packed operand vectors.
  always_comb begin
    grant_oh = '0;
    a_sel    = '0;
    b_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.found && (pick.idx == MAX_IDX_W'(i))) begin
        grant_oh[i] = 1'b1;
        a_sel       = req_a[i*WIDTH +: WIDTH];
        b_sel       = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  adder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i     (a_sel),
    .b_i     (b_sel),
    .sum_o   (core_sum),
    .carry_o (core_carry),
    .ovf_o   (core_ovf)
  );

  // rsp_valid is one-hot, so masking with rsp_ready picks out only the
  // owner's ready bit; everyone else's rsp_ready is ignored.
  assign out_busy   = |rsp_valid_q;
  assign drain      = |(rsp_valid_q & rsp_ready);
  assign can_accept = !out_busy || drain;
  assign accept     = rst_n && pick.found && can_accept;

  // Grant is gated by rst_n: the registers already read as empty in reset,
  // which would otherwise let a request through while reset is held.
  assign req_ready = (rst_n && can_accept) ? grant_oh : '0;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_carry_d = rsp_carry_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;
    if (accept) begin
      rsp_valid_d = grant_oh;
      rsp_sum_d   = core_sum;
      rsp_ovf_d   = core_ovf;
      rsp_carry_d = core_carry;
      rsp_id_d    = IDX_W'(pick.idx);
      // Pointer moves just past the winner so it has lowest priority next.
      if (pick.idx == MAX_IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = IDX_W'(pick.idx + 1'b1);
      end
    end else if (drain) begin
      // Only the valid flag clears; payload holds for observability.
      rsp_valid_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - scoreboard bench for adder_arbiter with directed vectors

module tb_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  rv;
  logic [2:0]  rr;
  logic [31:0] opa [3];
  logic [31:0] opb [3];
  logic [31:0] esum [3];
  logic        eovf [3];
  logic        ecar [3];

  logic [95:0] req_a;
  logic [95:0] req_b;
  logic [2:0]  req_ready;
  logic [2:0]  rsp_valid;
  logic [31:0] rsp_sum;
  logic        rsp_ovf;
  logic        rsp_carry;
  logic [1:0]  rsp_id;

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        ovf;
    logic        carry;
  } exp_t;

  exp_t sb [$];
  int   pass_cnt;
  int   tot_cnt;

  assign req_a = {opa[2], opa[1], opa[0]};
  assign req_b = {opb[2], opb[1], opb[0]};

  adder_arbiter #(
    .NUM_REQ (3),
    .WIDTH   (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (rv),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rr),
    .rsp_sum   (rsp_sum),
    .rsp_ovf   (rsp_ovf),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s, input logic o, input logic c);
    opa[i]  = a;
    opb[i]  = b;
    esum[i] = s;
    eovf[i] = o;
    ecar[i] = c;
  endtask

  // One cycle: check the grant at the falling edge, queue the expected
  // response for the granted requester, then step past the rising edge.
  task automatic cyc(input logic [2:0] exp_rdy, input bit push);
    exp_t e;
    int   idx;
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (push && (exp_rdy != 3'b000)) begin
      idx     = exp_rdy[1] ? 1 : (exp_rdy[2] ? 2 : 0);
      e.id    = idx;
      e.sum   = esum[idx];
      e.ovf   = eovf[idx];
      e.carry = ecar[idx];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every response handshake and checks hold stability.
  bit          stall_prev;
  logic [31:0] prev_sum;
  logic [1:0]  prev_id;
  logic [2:0]  prev_valid;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      chk("rsp_valid_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
      if (stall_prev) begin
        chk("hold_sum", 64'(rsp_sum), 64'(prev_sum));
        chk("hold_id", 64'(rsp_id), 64'(prev_id));
        chk("hold_valid", 64'(rsp_valid), 64'(prev_valid));
      end
      if (|(rsp_valid & rr)) begin
        if (sb.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_rsp: got id %0d sum %0h with no expected entry", rsp_id, rsp_sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(3'b001 << e.id));
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
          chk("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
          chk("rsp_carry", 64'(rsp_carry), 64'(e.carry));
        end
      end
      stall_prev = (|rsp_valid) && !(|(rsp_valid & rr));
      prev_sum   = rsp_sum;
      prev_id    = rsp_id;
      prev_valid = rsp_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          vid [6];
  logic [31:0] va  [6];
  logic [31:0] vb  [6];
  logic [31:0] vs  [6];
  logic        vo  [6];
  logic        vc  [6];

  initial begin
    pass_cnt = 0;
    tot_cnt  = 0;
    rst_n    = 1'b0;
    rv       = 3'b001;
    rr       = 3'b111;
    for (int i = 0; i < 3; i++) set_op(i, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_op(0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);

    // Reset state; grant forced low even with a request pending.
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst_rsp_ovf", 64'(rsp_ovf), 64'd0);
    chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single requester, 5+7.
    cyc(3'b001, 1);
    rv = 3'b000;
    cyc(3'b000, 1);

    // 2: all three requesting continuously; ptr starts at 1.
    vid = '{1, 2, 0, 1, 2, 0};
    va  = '{32'h0000_0100, 32'h0000_1000, 32'hFFFF_0000, 32'h1234_5678, 32'h4000_0000, 32'hFFFF_FFFE};
    vb  = '{32'h0000_0023, 32'h0000_0234, 32'h0000_FFFF, 32'h1111_1111, 32'h4000_0000, 32'h0000_0003};
    vs  = '{32'h0000_0123, 32'h0000_1234, 32'hFFFF_FFFF, 32'h2345_6789, 32'h8000_0000, 32'h0000_0001};
    vo  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) set_op(vid[k], va[k], vb[k], vs[k], vo[k], vc[k]);
    rv = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cyc(3'b001 << vid[k], 1);
      if (k + 3 < 6) set_op(vid[k], va[k+3], vb[k+3], vs[k+3], vo[k+3], vc[k+3]);
      else rv[vid[k]] = 1'b0;
    end

    // 3: backpressure on requester 1 while 0 and 2 wait.
    set_op(1, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0);
    rv = 3'b010;
    cyc(3'b010, 1);
    rr = 3'b101;
    rv = 3'b101;
    set_op(0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    set_op(2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_rsp_sum", 64'(rsp_sum), 64'h30);
      chk("stall_rsp_id", 64'(rsp_id), 64'd1);
      @(posedge clk);
      #1;
    end
    rr = 3'b111;
    cyc(3'b100, 1);
    rv = 3'b001;
    cyc(3'b001, 1);

    // 4: remaining arithmetic edges.
    rv = 3'b010;
    set_op(1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    cyc(3'b010, 1);
    rv = 3'b100;
    set_op(2, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1);
    cyc(3'b100, 1);
    rv = 3'b000;
    cyc(3'b000, 1);

    // 5: reset while requester 1's result is held and ptr=2.
    rr = 3'b101;
    rv = 3'b010;
    set_op(1, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);
    cyc(3'b010, 0);
    rv = 3'b110;
    set_op(1, 32'h20, 32'h22, 32'h42, 1'b0, 1'b0);
    set_op(2, 32'd9, 32'd1, 32'd10, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_req_ready", 64'(req_ready), 64'd0);
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rr    = 3'b111;
    cyc(3'b010, 1);
    rv = 3'b100;
    cyc(3'b100, 1);
    rv = 3'b000;
    cyc(3'b000, 1);

    // 6: idle cycles must not move the pointer.
    rv = 3'b001;
    set_op(0, 32'h11, 32'h22, 32'h33, 1'b0, 1'b0);
    cyc(3'b001, 1);
    rv = 3'b000;
    repeat (5) cyc(3'b000, 1);
    rv = 3'b101;
    set_op(0, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    set_op(2, 32'h100, 32'h200, 32'h300, 1'b0, 1'b0);
    cyc(3'b100, 1);
    rv = 3'b001;
    cyc(3'b001, 1);
    rv = 3'b000;
    cyc(3'b000, 1);
    cyc(3'b000, 1);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
